// File: rtl/ovl_fire_collector_if.sv
// ---------------------------------------------------------------------------
// ovl_fire_collector_if
// Record readout channel of the OVL fire collector (valid/ready).
//   rec_valid : head record present (collector -> consumer)
//   rec_ready : consumer accepts the head record (consumer -> collector)
//   rec_data  : {timestamp, fire snapshot} of the head record
// Modports: master = collector side, slave = consumer side.
// ---------------------------------------------------------------------------
interface ovl_fire_collector_if #(
    parameter int DATA_W = 28
) ();
    logic              rec_valid;
    logic              rec_ready;
    logic [DATA_W-1:0] rec_data;

    modport master (output rec_valid, output rec_data, input rec_ready);
    modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/ovl_fire_collector.sv
// ---------------------------------------------------------------------------
// ovl_fire_collector
// Samples the 3-bit fire buses of NUM_CHK OVL checkers, time-stamps every
// non-zero snapshot into a record FIFO read out over a valid/ready channel,
// and keeps per-checker saturating fail counters plus first-failure capture.
// Ports:
//   clk, reset_n  clock / asynchronous active-low reset
//   enable        capture fires and advance the timestamp
//   clear         synchronous clear of all state (wins over everything else)
//   fire_in       checker i at [3i+2:3i]: b0 assert, b1 xcheck, b2 cover
//   rec           record readout channel (master side)
//   fail_cnt      checker i fail count at [i*CNT_WIDTH +: CNT_WIDTH]
//   any_fail      sticky: some assert/xcheck fire seen
//   first_id      lowest checker index failing in the first failing cycle
//   first_ts      timestamp of the first failing cycle
//   overflow      sticky: a record was dropped on a full FIFO
//   drop_cnt      saturating count of dropped records
//   fifo_level    records currently held
// ---------------------------------------------------------------------------
module ovl_fire_collector #(
    parameter int NUM_CHK    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_WIDTH   = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               enable,
    input  logic                               clear,
    input  logic [3*NUM_CHK-1:0]               fire_in,
    ovl_fire_collector_if.master               rec,
    output logic [NUM_CHK*CNT_WIDTH-1:0]       fail_cnt,
    output logic                               any_fail,
    output logic [7:0]                         first_id,
    output logic [TS_WIDTH-1:0]                first_ts,
    output logic                               overflow,
    output logic [CNT_WIDTH-1:0]               drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level
);
    localparam int REC_W = TS_WIDTH + 3*NUM_CHK;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [TS_WIDTH-1:0]  ts_reg;
    logic [REC_W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]     level_reg;
    logic                 any_fail_reg, overflow_reg;
    logic [7:0]           first_id_reg, low_id_next;
    logic [TS_WIDTH-1:0]  first_ts_reg;
    logic [CNT_WIDTH-1:0] drop_cnt_reg;
    logic [CNT_WIDTH-1:0] cnt_reg [NUM_CHK];
    logic [NUM_CHK-1:0]   fail_vec;

    logic capture, full, pop, push, drop;

    assign capture = enable && (|fire_in);
    assign full    = (level_reg == LVL_W'(FIFO_DEPTH));
    assign pop     = (level_reg != '0) && rec.rec_ready;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    // Outputs derive from registered state only; the data is forced to zero
    // while empty so reset/clear present an all-zero record port.
    assign rec.rec_valid = (level_reg != '0);
    assign rec.rec_data  = rec.rec_valid ? mem[rd_ptr_reg] : '0;
    assign fifo_level    = level_reg;
    assign any_fail      = any_fail_reg;
    assign first_id      = first_id_reg;
    assign first_ts      = first_ts_reg;
    assign overflow      = overflow_reg;
    assign drop_cnt      = drop_cnt_reg;

    // Record storage: no reset needed, contents are only visible when valid.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr_reg] <= {ts_reg, fire_in};
        end
    end

    // Timestamp and FIFO bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_reg       <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (clear) begin
            ts_reg       <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            if (enable) begin
                ts_reg <= ts_reg + 1'b1;
            end
            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                level_reg <= level_reg + 1'b1;
            end else if (pop && !push) begin
                level_reg <= level_reg - 1'b1;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_cnt_reg != '1) begin
                    drop_cnt_reg <= drop_cnt_reg + 1'b1;
                end
            end
        end
    end

    // Per-checker fail detection and saturating counters.
    for (genvar gi = 0; gi < NUM_CHK; gi++) begin : g_chk
        assign fail_vec[gi] = enable && (fire_in[3*gi] || fire_in[3*gi+1]);
        assign fail_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg[gi];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_reg[gi] <= '0;
            end else if (clear) begin
                cnt_reg[gi] <= '0;
            end else if (fail_vec[gi] && (cnt_reg[gi] != '1)) begin
                cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
        end
    end

    // Lowest failing index: scan downward so the smallest index wins.
    always_comb begin
        low_id_next = '0;
        for (int i = NUM_CHK - 1; i >= 0; i--) begin
            if (fail_vec[i]) begin
                low_id_next = 8'(i);
            end
        end
    end

    // First-failure capture, frozen once any_fail is set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            any_fail_reg <= 1'b0;
            first_id_reg <= '0;
            first_ts_reg <= '0;
        end else if (clear) begin
            any_fail_reg <= 1'b0;
            first_id_reg <= '0;
            first_ts_reg <= '0;
        end else if (!any_fail_reg && (|fail_vec)) begin
            any_fail_reg <= 1'b1;
            first_id_reg <= low_id_next;
            first_ts_reg <= ts_reg;
        end
    end
endmodule
